acq_scheduler: RTL and testbench

Channel scan controller that sequences the ADC read block across a multiplexed set of analog inputs. Per enabled channel it selects the mux, waits a programmable settling time, pulses start_conv, and waits for the conversion handshake on complete. It then captures the two data words and range code, tagged with the channel number, and presents them downstream on a valid/ready handshake. Single-scan and continuous modes; a per-conversion watchdog guards against a stalled ADC.

---
 rtl/acq_scheduler.sv | 173 +++++++++++++++++
 tb/tb_acq_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_scheduler.sv
// Scans enabled mux channels: select, settle, start a conversion, capture the result and hand it downstream.
// First start_conv comes settle_cfg+2 cycles after enable; a result is held until res_ready, and no new conversion starts meanwhile.
module acq_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int CH_WIDTH     = 2,
    parameter int DATA_WIDTH   = 24,
    parameter int DIAP_WIDTH   = 2,
    parameter int SETTLE_WIDTH = 8,
    parameter int ACK_TIMEOUT  = 8,
    parameter int CONV_TIMEOUT = 65535,
    parameter int TMO_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    cont_mode,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [SETTLE_WIDTH-1:0] settle_cfg,
    output logic [CH_WIDTH-1:0]     mux_sel,
    output logic                    start_conv,
    input  logic                    complete,
    input  logic [DATA_WIDTH-1:0]   data_in_1,
    input  logic [DATA_WIDTH-1:0]   data_in_2,
    input  logic [DIAP_WIDTH-1:0]   diap_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CH_WIDTH-1:0]     res_ch,
    output logic [DATA_WIDTH-1:0]   res_data_1,
    output logic [DATA_WIDTH-1:0]   res_data_2,
    output logic [DIAP_WIDTH-1:0]   res_diap,
    output logic                    busy,
    output logic                    scan_done,
    output logic                    timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_OUTPUT
    } state_t;

    // One extra bit so the pointer can step past the last channel.
    localparam int PTR_W = CH_WIDTH + 1;
    localparam logic [TMO_WIDTH-1:0] ACK_LIM  = TMO_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [TMO_WIDTH-1:0] CONV_LIM = TMO_WIDTH'(CONV_TIMEOUT - 1);

    state_t                  state;
    logic [NUM_CH-1:0]       scan_mask;
    logic [PTR_W-1:0]        ptr;
    logic [SETTLE_WIDTH-1:0] settle_cnt;
    logic [TMO_WIDTH-1:0]    wd;
    logic                    found;
    logic [CH_WIDTH-1:0]     next_ch;
    logic [PTR_W-1:0]        ptr_after;

    // Lowest enabled channel at or above the pointer.
    always_comb begin
        found   = 1'b0;
        next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (scan_mask[i] && (i >= int'(ptr))) begin
                found   = 1'b1;
                next_ch = CH_WIDTH'(i);
            end
        end
    end

    assign ptr_after = PTR_W'(mux_sel) + PTR_W'(1);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            scan_mask   <= '0;
            ptr         <= '0;
            settle_cnt  <= '0;
            wd          <= '0;
            mux_sel     <= '0;
            start_conv  <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_data_1  <= '0;
            res_data_2  <= '0;
            res_diap    <= '0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            start_conv <= 1'b0;
            scan_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && (ch_mask != '0)) begin
                        scan_mask   <= ch_mask;
                        ptr         <= '0;
                        timeout_err <= 1'b0;
                        state       <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    // enable dropped mid-scan: stop without a scan_done pulse.
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (found) begin
                        mux_sel    <= next_ch;
                        settle_cnt <= settle_cfg;
                        state      <= S_SETTLE;
                    end else begin
                        scan_done <= 1'b1;
                        if (cont_mode && (ch_mask != '0)) begin
                            scan_mask <= ch_mask;
                            ptr       <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        start_conv <= 1'b1;
                        state      <= S_START;
                    end else begin
                        settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
                    end
                end
                S_START: begin
                    wd    <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!complete) begin
                        wd    <= '0;
                        state <= S_WAIT_DONE;
                    end else if (wd == ACK_LIM) begin
                        timeout_err <= 1'b1;
                        ptr         <= ptr_after;
                        state       <= S_SELECT;
                    end else begin
                        wd <= wd + TMO_WIDTH'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (complete) begin
                        res_ch     <= mux_sel;
                        res_data_1 <= data_in_1;
                        res_data_2 <= data_in_2;
                        res_diap   <= diap_in;
                        res_valid  <= 1'b1;
                        state      <= S_OUTPUT;
                    end else if (wd == CONV_LIM) begin
                        timeout_err <= 1'b1;
                        ptr         <= ptr_after;
                        state       <= S_SELECT;
                    end else begin
                        wd <= wd + TMO_WIDTH'(1);
                    end
                end
                S_OUTPUT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= ptr_after;
                        state     <= S_SELECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_scheduler.sv
// Randomized bench for acq_scheduler with a behavioural ADC and a channel-order reference model.
module tb_acq_scheduler;

    typedef struct packed {
        logic [1:0]  ch;
        logic [23:0] d1;
        logic [23:0] d2;
        logic [1:0]  dp;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        cont_mode = 1'b0;
    logic [3:0]  ch_mask = '0;
    logic [7:0]  settle_cfg = '0;
    logic [1:0]  mux_sel;
    logic        start_conv;
    logic        complete = 1'b1;
    logic [23:0] data_in_1 = '0;
    logic [23:0] data_in_2 = '0;
    logic [1:0]  diap_in = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [1:0]  res_ch;
    logic [23:0] res_data_1;
    logic [23:0] res_data_2;
    logic [1:0]  res_diap;
    logic        busy;
    logic        scan_done;
    logic        timeout_err;

    res_t got_q[$];
    res_t exp_q[$];
    res_t adc_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   n_start = 0;
    int   n_done = 0;
    int   adc_lat = 10;
    bit   adc_stuck = 1'b0;

    always #5 clk = ~clk;

    acq_scheduler #(
        .NUM_CH(4), .CH_WIDTH(2), .DATA_WIDTH(24), .DIAP_WIDTH(2), .SETTLE_WIDTH(8),
        .ACK_TIMEOUT(8), .CONV_TIMEOUT(65535), .TMO_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cont_mode(cont_mode), .ch_mask(ch_mask),
        .settle_cfg(settle_cfg), .mux_sel(mux_sel), .start_conv(start_conv), .complete(complete),
        .data_in_1(data_in_1), .data_in_2(data_in_2), .diap_in(diap_in), .res_valid(res_valid),
        .res_ready(res_ready), .res_ch(res_ch), .res_data_1(res_data_1), .res_data_2(res_data_2),
        .res_diap(res_diap), .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
    );

    // ADC: drops complete when a conversion starts, raises it adc_lat cycles later with fresh data.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (start_conv && !adc_stuck) begin
                complete = 1'b0;
                repeat (adc_lat - 1) @(negedge clk);
                r.ch = '0;
                r.d1 = 24'($urandom);
                r.d2 = 24'($urandom);
                r.dp = 2'($urandom);
                data_in_1 = r.d1;
                data_in_2 = r.d2;
                diap_in   = r.dp;
                complete  = 1'b1;
                adc_q.push_back(r);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (res_valid && res_ready) got_q.push_back({res_ch, res_data_1, res_data_2, res_diap});
                if (start_conv) n_start++;
                if (scan_done) n_done++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    // Reference: a scan visits the set mask bits in ascending order, one ADC result each.
    function automatic void build_exp(input logic [3:0] mask, input int scans);
        res_t e;
        for (int s = 0; s < scans; s++) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    if (adc_q.size() > 0) e = adc_q.pop_front();
                    else e = 'x;
                    e.ch = 2'(i);
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    task automatic begin_scan(input logic [3:0] mask, input logic [7:0] st, input bit cont);
        @(negedge clk);
        got_q.delete(); exp_q.delete(); adc_q.delete();
        n_start = 0; n_done = 0;
        ch_mask = mask; settle_cfg = st; cont_mode = cont; enable = 1'b1;
    endtask

    task automatic finish_scan(input int bound, input bit rand_ready, output bit tmo);
        tmo = 1'b1;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (scan_done) begin
                tmo = 1'b0;
                break;
            end
            if (rand_ready) res_ready = 1'($urandom_range(0, 1));
        end
        enable = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({mux_sel, start_conv, res_valid, res_ch, res_data_1, res_data_2, res_diap, busy, scan_done, timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b res_valid=%b mux=%0d want all zero", busy, res_valid, mux_sel);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_single;
        bit tmo;
        adc_lat = 10; res_ready = 1'b1; adc_stuck = 1'b0;
        begin_scan(4'b1010, 8'd3, 1'b0);
        finish_scan(2000, 1'b0, tmo);
        vectors++;
        if (tmo !== 1'b0) begin miscompares++; $display("FAIL single_scan_done got timeout want scan_done"); end
        vectors++;
        if (n_done !== 1) begin miscompares++; $display("FAIL single_done_count got %0d want 1", n_done); end
        vectors++;
        if (n_start !== 2) begin miscompares++; $display("FAIL single_starts got %0d want 2", n_start); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy got %b want 0", busy); end
        build_exp(4'b1010, 1);
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL single_res%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit   tmo;
        res_t hold;
        adc_lat = 6; res_ready = 1'b0;
        begin_scan(4'b0011, 8'd2, 1'b0);
        tmo = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (res_valid) begin tmo = 1'b0; break; end
        end
        vectors++;
        if (tmo !== 1'b0) begin miscompares++; $display("FAIL bp_first_valid got timeout want res_valid"); end
        hold = {res_ch, res_data_1, res_data_2, res_diap};
        vectors++;
        if (hold.ch !== 2'd0) begin miscompares++; $display("FAIL bp_first_ch got %0d want 0", hold.ch); end
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if ({res_valid, res_ch, res_data_1, res_data_2, res_diap} !== {1'b1, hold}) begin
                miscompares++; $display("FAIL bp_hold got v=%b %h want v=1 %h", res_valid, {res_ch, res_data_1, res_data_2, res_diap}, hold);
            end
        end
        vectors++;
        if (n_start !== 1) begin miscompares++; $display("FAIL bp_no_start got %0d starts want 1", n_start); end
        res_ready = 1'b1;
        finish_scan(2000, 1'b0, tmo);
        vectors++;
        if (tmo !== 1'b0) begin miscompares++; $display("FAIL bp_scan_done got timeout want scan_done"); end
        build_exp(4'b0011, 1);
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL bp_res%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_continuous;
        int cnt = 0;
        bit tmo = 1'b1;
        adc_lat = $urandom_range(4, 12);
        begin_scan(4'b0001, 8'd1, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (scan_done) begin
                cnt++;
                // The third pulse coincides with the relatch, so the new mask lands one scan later.
                if (cnt == 3) ch_mask = 4'b0100;
                if (cnt == 5) begin enable = 1'b0; tmo = 1'b0; break; end
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (tmo !== 1'b0) begin miscompares++; $display("FAIL cont_scans got %0d scan_done want 5", cnt); end
        vectors++;
        if (n_done !== 5) begin miscompares++; $display("FAIL cont_done_count got %0d want 5", n_done); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL cont_stop_busy got %b want 0", busy); end
        build_exp(4'b0001, 4);
        build_exp(4'b0100, 1);
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL cont_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL cont_res%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        cont_mode = 1'b0;
    endtask

    task automatic test_watchdog;
        bit tmo = 1'b1;
        bit saw_valid = 1'b0;
        int k = -1;
        adc_lat = 8; adc_stuck = 1'b1;
        begin_scan(4'b0011, 8'd3, 1'b0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (start_conv) begin tmo = 1'b0; break; end
        end
        vectors++;
        if (tmo !== 1'b0) begin miscompares++; $display("FAIL wd_start got timeout want start_conv"); end
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (res_valid) saw_valid = 1'b1;
            if (timeout_err) begin k = c; break; end
        end
        adc_stuck = 1'b0;
        vectors++;
        if (k < 8 || k > 10) begin miscompares++; $display("FAIL wd_latency got %0d cycles want 8..10", k); end
        vectors++;
        if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL wd_no_result got res_valid=1 want 0"); end
        finish_scan(2000, 1'b0, tmo);
        vectors++;
        if (tmo !== 1'b0) begin miscompares++; $display("FAIL wd_scan_done got timeout want scan_done"); end
        vectors++;
        if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL wd_sticky got %b want 1", timeout_err); end
        vectors++;
        if (n_start !== 2) begin miscompares++; $display("FAIL wd_starts got %0d want 2", n_start); end
        build_exp(4'b0010, 1);
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL wd_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL wd_res%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        begin_scan(4'b0001, 8'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL wd_clear got %b want 0", timeout_err); end
        finish_scan(2000, 1'b0, tmo);
    endtask

    task automatic test_edge;
        bit   tmo;
        int   seen;
        logic [7:0] st;
        begin_scan(4'b0000, 8'd0, 1'b0);
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || start_conv !== 1'b0) begin
                miscompares++; $display("FAIL edge_zero_mask got busy=%b start=%b want 0 0", busy, start_conv);
            end
        end
        enable = 1'b0;
        for (int r = 0; r < 3; r++) begin
            st = (r == 0) ? 8'd0 : 8'($urandom_range(1, 9));
            adc_lat = 5;
            begin_scan(4'b0001, st, 1'b0);
            seen = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (start_conv) begin seen = i; break; end
            end
            vectors++;
            if (seen !== int'(st) + 2) begin
                miscompares++; $display("FAIL edge_start_delay settle=%0d got %0d want %0d", st, seen, int'(st) + 2);
            end
            finish_scan(2000, 1'b0, tmo);
            vectors++;
            if (tmo !== 1'b0) begin miscompares++; $display("FAIL edge_scan_done got timeout want scan_done"); end
        end
    endtask

    task automatic test_random;
        bit tmo;
        logic [3:0] mask;
        for (int r = 0; r < 5; r++) begin
            mask = 4'($urandom_range(1, 15));
            adc_lat = $urandom_range(4, 12);
            begin_scan(mask, 8'($urandom_range(0, 4)), 1'b0);
            finish_scan(3000, 1'b1, tmo);
            vectors++;
            if (tmo !== 1'b0) begin miscompares++; $display("FAIL rand_scan_done mask=%b got timeout want scan_done", mask); end
            vectors++;
            if (n_start !== $countones(mask)) begin
                miscompares++; $display("FAIL rand_starts mask=%b got %0d want %0d", mask, n_start, $countones(mask));
            end
            build_exp(mask, 1);
            vectors++;
            if (got_q.size() !== exp_q.size()) begin
                miscompares++; $display("FAIL rand_count mask=%b got %0d want %0d", mask, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++; $display("FAIL rand_res%0d mask=%b got %h want %h", i, mask, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit tmo = 1'b1;
        adc_lat = 60;
        begin_scan(4'b0100, 8'd1, 1'b0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (start_conv) begin tmo = 1'b0; break; end
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (tmo !== 1'b0 || busy !== 1'b1 || mux_sel !== 2'd2) begin
            miscompares++; $display("FAIL rstmid_pre got busy=%b mux=%0d want 1 2", busy, mux_sel);
        end
        #2;
        rst = 1'b0;
        enable = 1'b0;
        #1;
        vectors++;
        if ({mux_sel, start_conv, res_valid, res_ch, res_data_1, res_data_2, res_diap, busy, scan_done, timeout_err} !== '0) begin
            miscompares++; $display("FAIL rstmid_outputs got busy=%b mux=%0d res_valid=%b want all zero", busy, mux_sel, res_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got busy=%b want 0", busy); end
        for (int c = 0; c < 100 && !complete; c++) @(negedge clk);
        adc_q.delete();
        got_q.delete();
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_continuous;
        test_watchdog;
        test_edge;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
